// File: rtl/demux_1x4_stream.sv
// Packet-locked 1-to-4 stream demux with a one-entry register slice per output.
// Optional per-channel packet counters on xfer_cnt when DEMUX_1X4_CNT_EN is defined.
module demux_1x4_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [1:0]       select,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  output logic [3:0]       out_last,
  input  logic [3:0]       out_ready
`ifdef DEMUX_1X4_CNT_EN
  ,
  output logic [63:0]      xfer_cnt
`endif
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       dst;
  logic             accept;
  logic [3:0]       load;
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       last_q, last_d;
  logic [WIDTH-1:0] data_q [4];

  always_comb begin
    dst      = (state_q == BUSY) ? sel_q : select;
    in_ready = !valid_q[dst] || out_ready[dst];
    accept   = in_valid && in_ready;
    load     = accept ? (4'b0001 << dst) : 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = select;
          if (!in_last) state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A load on a draining slice keeps valid high: no bubble.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    for (int i = 0; i < 4; i++) begin
      if (load[i]) begin
        valid_d[i] = 1'b1;
        last_d[i]  = in_last;
      end else if (out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      valid_q <= 4'b0000;
      last_q  <= 4'b0000;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int i = 0; i < 4; i++)
        if (load[i]) data_q[i] <= in;
    end
  end

  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out_valid = valid_q;
  assign out_last  = last_q;

`ifdef DEMUX_1X4_CNT_EN
  logic [15:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (valid_q[i] && out_ready[i] && last_q[i] &&
            cnt_q[i] != 16'hFFFF)
          cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  assign xfer_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Scoreboard bench for demux_1x4_stream: directed packets then random traffic.
// Expected beats queue per channel; a monitor pops them as outputs handshake.
module tb_demux_1x4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic        in_valid;
  logic        in_last;
  logic [1:0]  select;
  logic        in_ready;
  logic [31:0] out0, out1, out2, out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_last;
  logic [3:0]  out_ready;
`ifdef DEMUX_1X4_CNT_EN
  logic [63:0] xfer_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q [4][$];
  bit    busy_m = 0;
  logic [1:0] lock_m = 2'd0;
  int    cnt_m [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  demux_1x4_stream #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .in_last  (in_last),
    .select   (select),
    .in_ready (in_ready),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ready(out_ready)
`ifdef DEMUX_1X4_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  function automatic logic [31:0] out_of(input int i);
    case (i)
      0:       return out0;
      1:       return out1;
      2:       return out2;
      default: return out3;
    endcase
  endfunction

  // Reference: a packet owns its channel until its last beat; each channel
  // holds at most one beat, so input may enter only if that beat is gone.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        cnt_m[i] = 0;
      end
      busy_m = 0;
      lock_m = 2'd0;
    end else begin
      logic [1:0] d;
      logic       rdy;
      d   = busy_m ? lock_m : select;
      rdy = (exp_q[d].size() == 0);
      checks++;
      if (in_ready !== rdy) begin
        fails++;
        $display("FAIL in_ready t=%0t got=%b exp=%b dst=%0d",
                 $time, in_ready, rdy, d);
      end
      if (in_valid && rdy) begin
        exp_q[d].push_back('{data: in, last: in_last});
        if (!busy_m && !in_last) begin
          busy_m = 1;
          lock_m = select;
        end else if (busy_m && in_last) begin
          busy_m = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
`ifdef DEMUX_1X4_CNT_EN
      checks++;
      if (xfer_cnt !== {cnt_m[3][15:0], cnt_m[2][15:0],
                        cnt_m[1][15:0], cnt_m[0][15:0]}) begin
        fails++;
        $display("FAIL xfer_cnt t=%0t got=%h exp=%0d,%0d,%0d,%0d",
                 $time, xfer_cnt, cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]);
      end
`endif
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_valid[i] !== (exp_q[i].size() != 0)) begin
          fails++;
          $display("FAIL out_valid[%0d] t=%0t got=%b exp=%b",
                   i, $time, out_valid[i], exp_q[i].size() != 0);
        end
        if (out_valid[i] && out_ready[i] && exp_q[i].size() != 0) begin
          beat_t b;
          b = exp_q[i].pop_front();
          checks++;
          if (out_of(i) !== b.data || out_last[i] !== b.last) begin
            fails++;
            $display("FAIL beat ch%0d t=%0t got=%h/%b exp=%h/%b",
                     i, $time, out_of(i), out_last[i], b.data, b.last);
          end
          if (b.last) cnt_m[i]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] s,
                      input logic l);
    int n;
    n = 0;
    in       = d;
    select   = s;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fails++;
      $display("FAIL send_timeout data=%h got_ready=0 exp_ready=1", d);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_eq(input string name, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in        = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    select    = 2'd0;
    out_ready = 4'b1111;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", {60'd0, out_valid}, 64'd0);
    check_eq("rst_last", {60'd0, out_last}, 64'd0);
    check_eq("rst_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_data", {out0 | out1, out2 | out3}, 64'd0);
    tick();

    send(32'hA5A5_0001, 2'd2, 1'b1);
    @(negedge clk);
    check_eq("single_out2", {32'd0, out2}, {32'd0, 32'hA5A5_0001});
    tick();

    send(32'h1000_0000, 2'd1, 1'b0);
    for (int k = 1; k < 4; k++)
      send(32'h1000_0000 + k, 2'd3, k == 3);
    repeat (2) tick();

    out_ready = 4'b1110;
    send(32'h2000_0000, 2'd0, 1'b0);
    fork
      send(32'h2000_0001, 2'd0, 1'b1);
      begin
        repeat (3) @(negedge clk);
        check_eq("stall_ready", {63'd0, in_ready}, 64'd0);
        check_eq("stall_hold", {32'd0, out0}, {32'd0, 32'h2000_0000});
        tick();
        out_ready = 4'b1111;
      end
    join
    send(32'h3000_0000, 2'd3, 1'b1);
    repeat (2) tick();

    for (int k = 0; k < 8; k++)
      send(32'h4000_0000 + k, 2'd2, k == 7);
    repeat (2) tick();

    send(32'h5000_0000, 2'd1, 1'b0);
    send(32'h5000_0001, 2'd1, 1'b0);
    in       = 32'h5000_0002;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_valid", {60'd0, out_valid}, 64'd0);
`ifdef DEMUX_1X4_CNT_EN
    check_eq("midrst_cnt", xfer_cnt, 64'd0);
`endif
    tick();
    send(32'h6000_0000, 2'd0, 1'b1);
    for (int p = 0; p < 2; p++) begin
      send(32'h7000_0000 + p, 2'd0, 1'b0);
      send(32'h7000_0100 + p, 2'd2, 1'b1);
    end
    repeat (3) tick();
`ifdef DEMUX_1X4_CNT_EN
    check_eq("cnt_ch0", {48'd0, xfer_cnt[15:0]}, 64'd3);
`endif

    for (int c = 0; c < 3000; c++) begin
      in        = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      select    = 2'($urandom_range(0, 3));
      out_ready = 4'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    repeat (4) tick();
    @(negedge clk);
    check_eq("drained", {32'd0, 32'(exp_q[0].size() + exp_q[1].size() +
             exp_q[2].size() + exp_q[3].size())}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- Packet-oriented 1-to-4 stream demultiplexer; counterpart of the 4-to-1 mux in the datapath library.
- Routes each input packet to one of four outputs (`out0`..`out3`) chosen by `select`.
- Select is locked for the whole packet; each output has a one-entry register slice with valid/ready handshake.
- Used wherever a shared bus fans out to four consumers.

Parameters:
- `WIDTH`, 32, data width in bits of the input and of each output.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in`  input  WIDTH  input beat data.
- `in_valid`  input  1  input beat valid.
- `in_last`  input  1  final beat of packet.
- `select`  input  2  destination; sampled on first beat of packet only.
- `in_ready`  output  1  demux can accept a beat this cycle.
- `out0`, `out1`, `out2`, `out3`  output  WIDTH  registered data per channel.
- `out_valid`  output  4  per-channel valid; bit i belongs to `out<i>`.
- `out_last`  output  4  per-channel last flag, qualified by `out_valid[i]`.
- `out_ready`  input  4  per-channel downstream ready.
- `xfer_cnt`  output  64  only with `DEMUX_1X4_CNT_EN`; see Optional Feature.

Behaviour:
- Reset (`rst`=1 at a rising edge): all `out_valid`=0, `out_last`=0, `out0`..`out3`=0, FSM to IDLE, locked select=0.
  - Reset wins over every simultaneous event.
  - Reset mid-packet discards the packet and any buffered beats.
- Effective destination `dst`:
  - `dst` = `select` in IDLE.
  - `dst` = locked select in BUSY.
- Slice i is free when `out_valid[i]`=0 or `out_ready[i]`=1.
- `in_ready` = slice `dst` free. Combinational; depends on `out_ready[dst]` and `select`, not on `in_valid`.
- Input handshake: beat accepted when `in_valid` && `in_ready`.
  - On accept, next cycle: `out<dst>`=`in`, `out_last[dst]`=`in_last`, `out_valid[dst]`=1.
  - Latency 1 cycle; full throughput of 1 beat/cycle when the consumer is always ready.
- Output handshake: beat i leaves when `out_valid[i]` && `out_ready[i]`.
  - If no new beat is loaded into slice i that cycle, `out_valid[i]` clears.
  - A simultaneous leave and load on the same slice keeps `out_valid[i]`=1 with the new data: no bubble.
- Non-selected slices hold data, valid and last while not ready.
  - Other channels drain independently while the input is stalled on `dst`.
- Output data and last hold stable while `out_valid[i]`=1 and `out_ready[i]`=0.
- FSM:
  - IDLE --accept & !`in_last`--> BUSY; locks select.
  - IDLE --accept & `in_last`--> IDLE; single-beat packet.
  - BUSY --accept & `in_last`--> IDLE.
  - BUSY otherwise stays BUSY.
- `select` changes during BUSY are ignored.
- `in_valid`=0 during BUSY (gap inside a packet) is legal and holds the lock.
- Back-to-back packets: the first beat after a last beat samples the new `select` in the same cycle the FSM returns to IDLE.
- No reordering; beats of a packet arrive at one output in input order.

Optional Feature:
- Macro: `DEMUX_1X4_CNT_EN`.
- Defined:
  - Adds four 16-bit packet counters packed in `xfer_cnt`; `[16i+15:16i]` belongs to channel i.
  - Counter i increments when a beat with `out_last[i]`=1 completes the output handshake on channel i.
  - Counters saturate at 16'hFFFF and do not wrap.
  - Counters clear to 0 on `rst`.
- Not defined: the `xfer_cnt` port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle with all `out_ready`=4'b1111 → `out_valid`=0, `in_ready`=1; `out0`..`out3`=0.
- Single beat `in`=32'hA5A5_0001, `select`=2, `in_last`=1, all ready → next cycle `out_valid`=4'b0100, `out2`=32'hA5A5_0001, `out_last[2]`=1; cleared the following cycle.
- 4-beat packet, `select`=1 on beat 0, `select` toggled to 3 on beats 1-3, all ready → all four beats appear on `out1` on consecutive cycles; `out_valid[3]` never set; `out_last[1]` only on beat 4.
- `out_ready[0]`=0 with 2 beats sent to channel 0 → first beat held on `out0`, `in_ready`=0.
  - Then a new packet to channel 3 is blocked until channel 0 drains.
  - After `out_ready[0]`=1 for 2 cycles → both beats delivered in order.
- Streaming 8 beats to channel 2 with `out_ready[2]`=1 constantly → `out_valid[2]` high for 8 consecutive cycles with no bubbles; `in_ready` stays 1.
- `rst` asserted during beat 2 of a 4-beat packet to channel 1 → next cycle `out_valid`=0, FSM IDLE; a following packet with `select`=0 routes to `out0`.
  - With `DEMUX_1X4_CNT_EN`: all counters read 0 after the reset; 3 completed packets to channel 0 then read `xfer_cnt[15:0]`=3.
